uart_cmd_sequencer: RTL and testbench
=====================================

Name: uart_cmd_sequencer

Overview:
Command sequencer between the UART core's received-frame output and the badge's challenge resources: cat LEDs, AES-128 key/plaintext registers, AES result readout and secret-flag transmit. It replaces ad-hoc per-cycle decoding. Each received frame is latched once, validated against its end character and dispatched. Every transmit request goes through a single handshake with the UART TX path.

Parameters:
DBITS, 8, bits per UART byte
FRAME_BYTES, 18, bytes per rx/tx frame (frame width W = DBITS*FRAME_BYTES = 144)
AES_LATENCY, 2, cycles waited after cmd 'D' before sampling aes_out
TX_ACK_TIMEOUT, 4, max cycles from tx_trigger to tx_busy rising

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
frame_valid  in  1  one-cycle pulse; frame holds a new complete rx frame
frame  in  W  rx frame; byte k = frame[8k+7:8k]; byte0 = command
tx_busy  in  1  UART transmitter busy
secret_flag  in  W  constant flag frame for cmd '@'
aes_out  in  128  ciphertext from the combinational AES core
tx_trigger  out  1  one-cycle pulse starting a transmit of tx_payload
tx_payload  out  W  frame to transmit; stable from trigger until tx_busy falls
aes_key  out  128  AES key register
aes_in  out  128  AES plaintext register
cat_status  out  8  active-low cat mask (1 = cat alive)
err_count  out  8  saturating count of rejected or dropped frames
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (async, active-high): state IDLE; tx_trigger 0; tx_payload 0; aes_key 0; aes_in 0; cat_status 8'hFF; err_count 0.
- States: IDLE, DECODE, AES_WAIT, TX_REQ, TX_WAIT.
- IDLE: on frame_valid, latch frame into frame_r and go to DECODE.
- DECODE: decode one cycle, using frame_r byte0 (cmd) and the end-character check.
  - 0x41 'A': valid iff byte2 == byte0.
    - byte1 in 0x41..0x48: clear cat_status[byte1-0x41].
    - byte1 == 0x60: cat_status <= 8'hFF.
    - other byte1: no change, not an error.
    - Next: IDLE.
  - 0x40 '@': valid iff byte17 == byte0. tx_payload <= secret_flag. Next: TX_REQ.
  - 0x42 'B': valid iff byte17 == byte0. aes_key <= frame_r[135:8]. Next: IDLE.
  - 0x43 'C': valid iff byte17 == byte0. aes_in <= frame_r[135:8]. Next: IDLE.
  - 0x44 'D': valid iff byte17 == byte0. Load counter with AES_LATENCY. Next: AES_WAIT.
  - Unknown cmd or failed end-char check: err_count+1 (saturates at 255). Next: IDLE.
- Latency: frame_valid in cycle N → register outputs updated at the clock edge ending cycle N+1, visible in cycle N+2.
- AES_WAIT: count down. At 0, tx_payload <= {8'h44, aes_out, 8'h44} (byte0 = 0x44, byte17 = 0x44). Next: TX_REQ.
- TX_REQ: if tx_busy == 0, pulse tx_trigger for 1 cycle and go to TX_WAIT. Otherwise hold.
- TX_WAIT, phase 1: wait for tx_busy to rise.
  - If it has not risen within TX_ACK_TIMEOUT cycles: err_count+1, go to IDLE.
- TX_WAIT, phase 2: wait for tx_busy to fall, then go to IDLE.
- frame_valid in any state other than IDLE: frame dropped, err_count+1. The current operation is unaffected.
- aes_key and aes_in change only in DECODE and are never touched during AES_WAIT/TX.
- Reset mid-operation: immediate return to reset values; no tx_trigger pulse is emitted on or after reset release until a new command arrives.
- tx_trigger is never high for 2 consecutive cycles.

Decomposition:
- Shared package uart_cmd_pkg holds:
  - command codes CMD_FLAG=0x40, CMD_CAT=0x41, CMD_KEY=0x42, CMD_PT=0x43, CMD_ENC=0x44;
  - CAT_BASE=0x41, CAT_RESET_CHAR=0x60;
  - the state enum;
  - FRAME_BYTES/DBITS defaults.
- One sub-module, uart_tx_handshake: TX_REQ/TX_WAIT logic and timeout counter. Interface: start, tx_busy, tx_trigger, done, timeout.

Test Plan:
- Cat clear: frame bytes {0x41,0x43,0x41} + frame_valid → cat_status 8'hFB two cycles later. Then {0x41,0x60,0x41} → 8'hFF. Then {0x41,0x49,0x41} → unchanged, err_count unchanged.
- Key/plaintext: 'B' frame with bytes1..16 = 0x00..0x0F and byte17 = 0x42 → aes_key = 128'h0F0E...0100. Same payload with byte17 = 0x43 → err_count = 1, aes_key unchanged.
- Encrypt: 'D' frame with tx_busy = 0 → tx_trigger pulse exactly 1+AES_LATENCY+2 cycles after frame_valid. tx_payload = {0x44, aes_out, 0x44}. busy stays high until tx_busy falls.
- Flag: '@' frame with byte17 = 0x40 while tx_busy = 1 → no trigger. Drop tx_busy → single tx_trigger pulse, tx_payload = secret_flag.
- Drop/timeout: frame_valid during AES_WAIT → err_count+1, encrypt still completes. tx_busy held 0 after trigger → err_count+1 after TX_ACK_TIMEOUT cycles, return to IDLE.
- Reset: assert reset during TX_WAIT → all outputs at reset values asynchronously, cat_status 8'hFF, no tx_trigger after release. Also check err_count saturates at 255 after 300 bad frames.

Source files
------------

// File: rtl/uart_cmd_sequencer_pkg.sv
// Shared constants, state encoding and helpers for the UART command sequencer.
package uart_cmd_pkg;

  localparam int DEF_DBITS       = 8;
  localparam int DEF_FRAME_BYTES = 18;
  localparam int DEF_FRAME_W     = DEF_DBITS * DEF_FRAME_BYTES;

  localparam logic [7:0] CMD_FLAG = 8'h40;
  localparam logic [7:0] CMD_CAT  = 8'h41;
  localparam logic [7:0] CMD_KEY  = 8'h42;
  localparam logic [7:0] CMD_PT   = 8'h43;
  localparam logic [7:0] CMD_ENC  = 8'h44;

  localparam logic [7:0] CAT_BASE       = 8'h41;
  localparam logic [7:0] CAT_RESET_CHAR = 8'h60;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_DECODE   = 3'd1,
    S_AES_WAIT = 3'd2,
    S_TX_REQ   = 3'd3,
    S_TX_WAIT  = 3'd4
  } seq_state_e;

  // Add a small increment to an 8-bit counter, clamping at 255.
  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [1:0] b);
    logic [9:0] s;
    s = {2'b00, a} + {8'h00, b};
    return (s > 10'd255) ? 8'hFF : s[7:0];
  endfunction

endpackage

// File: rtl/uart_cmd_sequencer_if.sv
// UART-side signals of the command sequencer: rx frame in, tx request out.
interface uart_cmd_sequencer_if import uart_cmd_pkg::*; #(
  parameter int W = DEF_FRAME_W
) ();
  logic         frame_valid;
  logic [W-1:0] frame;
  logic         tx_busy;
  logic         tx_trigger;
  logic [W-1:0] tx_payload;

  // Sequencer side
  modport master (
    input  frame_valid,
    input  frame,
    input  tx_busy,
    output tx_trigger,
    output tx_payload
  );

  // UART core side
  modport slave (
    output frame_valid,
    output frame,
    output tx_busy,
    input  tx_trigger,
    input  tx_payload
  );
endinterface

// File: rtl/uart_cmd_sequencer_tx_handshake.sv
// Single transmit handshake: request, wait for tx_busy to rise (bounded), then wait for it to fall.
module uart_tx_handshake #(
  parameter int TX_ACK_TIMEOUT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic tx_busy,
  output logic tx_trigger,
  output logic done,
  output logic timeout
);

  localparam logic [1:0] H_IDLE = 2'd0;
  localparam logic [1:0] H_ACK  = 2'd1;
  localparam logic [1:0] H_FALL = 2'd2;
  localparam int CW = (TX_ACK_TIMEOUT > 1) ? $clog2(TX_ACK_TIMEOUT + 1) : 1;

  logic [1:0]    hs_state;
  logic [CW-1:0] ack_cnt;

  // The trigger fires in the same cycle the transmitter is seen idle, so it can only last one cycle.
  assign tx_trigger = (hs_state == H_IDLE) && start && !tx_busy;
  assign done       = (hs_state == H_FALL) && !tx_busy;
  assign timeout    = (hs_state == H_ACK) && !tx_busy && (ack_cnt == '0);

  // Phase tracking and the acknowledge timeout down-counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hs_state <= H_IDLE;
      ack_cnt  <= '0;
    end else begin
      case (hs_state)
        H_IDLE: begin
          if (tx_trigger) begin
            hs_state <= H_ACK;
            ack_cnt  <= CW'(TX_ACK_TIMEOUT - 1);
          end
        end
        H_ACK: begin
          if (tx_busy)              hs_state <= H_FALL;
          else if (ack_cnt == '0)   hs_state <= H_IDLE;
          else                      ack_cnt  <= ack_cnt - CW'(1);
        end
        H_FALL: begin
          if (!tx_busy) hs_state <= H_IDLE;
        end
        default: hs_state <= H_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_cmd_sequencer.sv
// Latches received frames, validates the end character and dispatches to cat/AES/tx resources.
//
// state    | meaning
// IDLE     | waiting for frame_valid
// DECODE   | one-cycle decode of the latched frame
// AES_WAIT | counting down until aes_out is settled
// TX_REQ   | payload ready, waiting for the transmitter to be free
// TX_WAIT  | trigger sent, waiting for tx_busy to rise and then fall
module uart_cmd_sequencer import uart_cmd_pkg::*; #(
  parameter int DBITS          = DEF_DBITS,
  parameter int FRAME_BYTES    = DEF_FRAME_BYTES,
  parameter int AES_LATENCY    = 2,
  parameter int TX_ACK_TIMEOUT = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  uart_cmd_sequencer_if.master           uart,
  input  logic [DBITS*FRAME_BYTES-1:0]   secret_flag,
  input  logic [127:0]                   aes_out,
  output logic [127:0]                   aes_key,
  output logic [127:0]                   aes_in,
  output logic [7:0]                     cat_status,
  output logic [7:0]                     err_count,
  output logic                           busy
);

  localparam int W      = DBITS * FRAME_BYTES;
  localparam int AES_CW = (AES_LATENCY > 1) ? $clog2(AES_LATENCY + 1) : 1;

  localparam logic [2:0] IDLE     = S_IDLE;
  localparam logic [2:0] DECODE   = S_DECODE;
  localparam logic [2:0] AES_WAIT = S_AES_WAIT;
  localparam logic [2:0] TX_REQ   = S_TX_REQ;
  localparam logic [2:0] TX_WAIT  = S_TX_WAIT;

  logic [2:0]        state;
  logic [W-1:0]      frame_r;
  logic [W-1:0]      tx_payload_r;
  logic [AES_CW-1:0] aes_cnt;
  logic [DBITS-1:0]  cmd, b1, b2, b_end;
  logic [7:0]        cat_idx;
  logic              dec_err, drop, hs_trigger, hs_done, hs_timeout;

  assign cmd     = frame_r[0 +: DBITS];
  assign b1      = frame_r[DBITS +: DBITS];
  assign b2      = frame_r[2*DBITS +: DBITS];
  assign b_end   = frame_r[(FRAME_BYTES-1)*DBITS +: DBITS];
  assign cat_idx = b1 - CAT_BASE;

  assign busy            = (state != IDLE);
  assign drop            = uart.frame_valid && (state != IDLE);
  assign uart.tx_payload = tx_payload_r;
  assign uart.tx_trigger = hs_trigger;

  uart_tx_handshake #(.TX_ACK_TIMEOUT(TX_ACK_TIMEOUT)) u_tx_hs (
    .clk        (clk),
    .reset      (reset),
    .start      (state == TX_REQ),
    .tx_busy    (uart.tx_busy),
    .tx_trigger (hs_trigger),
    .done       (hs_done),
    .timeout    (hs_timeout)
  );

  // Rejection of the frame being decoded: unknown command or wrong end character.
  always_comb begin
    dec_err = 1'b0;
    if (state == DECODE) begin
      case (cmd)
        CMD_CAT:                              dec_err = (b2 != cmd);
        CMD_FLAG, CMD_KEY, CMD_PT, CMD_ENC:   dec_err = (b_end != cmd);
        default:                              dec_err = 1'b1;
      endcase
    end
  end

  // Main sequencer FSM and the registers it owns.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      frame_r      <= '0;
      aes_cnt      <= '0;
      tx_payload_r <= '0;
      aes_key      <= '0;
      aes_in       <= '0;
      cat_status   <= 8'hFF;
    end else begin
      case (state)
        IDLE: begin
          if (uart.frame_valid) begin
            frame_r <= uart.frame;
            state   <= DECODE;
          end
        end
        DECODE: begin
          state <= IDLE;
          if (!dec_err) begin
            case (cmd)
              CMD_CAT: begin
                if (b1 >= CAT_BASE && b1 <= CAT_BASE + 8'd7) cat_status[cat_idx[2:0]] <= 1'b0;
                else if (b1 == CAT_RESET_CHAR)               cat_status <= 8'hFF;
              end
              CMD_FLAG: begin
                tx_payload_r <= secret_flag;
                state        <= TX_REQ;
              end
              CMD_KEY: aes_key <= frame_r[(FRAME_BYTES-1)*DBITS-1:DBITS];
              CMD_PT:  aes_in  <= frame_r[(FRAME_BYTES-1)*DBITS-1:DBITS];
              CMD_ENC: begin
                aes_cnt <= AES_CW'(AES_LATENCY);
                state   <= AES_WAIT;
              end
              default: state <= IDLE;
            endcase
          end
        end
        AES_WAIT: begin
          if (aes_cnt == '0) begin
            tx_payload_r <= {CMD_ENC, aes_out, CMD_ENC};
            state        <= TX_REQ;
          end else begin
            aes_cnt <= aes_cnt - AES_CW'(1);
          end
        end
        TX_REQ: begin
          if (hs_trigger) state <= TX_WAIT;
        end
        TX_WAIT: begin
          if (hs_done || hs_timeout) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Error counter: decode rejects, frames dropped while busy, and tx acknowledge timeouts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) err_count <= 8'h00;
    else       err_count <= sat_add8(err_count, 2'({1'b0, drop} + {1'b0, dec_err} + {1'b0, hs_timeout}));
  end

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// Self-checking bench for uart_cmd_sequencer: directed scenarios plus randomized frames vs. a reference model.
module tb_uart_cmd_sequencer;

  localparam int W = 144;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] secret_flag;
  logic [127:0] aes_out, aes_key, aes_in;
  logic [7:0]   cat_status, err_count;
  logic         busy;

  uart_cmd_sequencer_if #(.W(W)) u_if ();

  uart_cmd_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .uart        (u_if),
    .secret_flag (secret_flag),
    .aes_out     (aes_out),
    .aes_key     (aes_key),
    .aes_in      (aes_in),
    .cat_status  (cat_status),
    .err_count   (err_count),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // reference model state
  logic [7:0]   m_cat, m_err;
  logic [127:0] m_key, m_pt;
  byte unsigned fb[18];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] pack_frame();
    logic [W-1:0] f;
    for (int k = 0; k < 18; k++) f[8*k +: 8] = fb[k];
    return f;
  endfunction

  task automatic clear_fb();
    for (int k = 0; k < 18; k++) fb[k] = 8'h00;
  endtask

  task automatic err_inc();
    if (m_err != 8'd255) m_err = m_err + 8'd1;
  endtask

  // Expected effect of the frame in fb, written from the command rules.
  task automatic apply_model(output bit do_tx, output logic [W-1:0] exp_pl);
    logic [127:0] body;
    byte unsigned cmd;
    cmd    = fb[0];
    do_tx  = 1'b0;
    exp_pl = '0;
    for (int i = 0; i < 16; i++) body[8*i +: 8] = fb[i+1];
    if (cmd == 8'h41) begin
      if (fb[2] != cmd) err_inc();
      else if (fb[1] >= 8'h41 && fb[1] <= 8'h48) m_cat[fb[1] - 8'h41] = 1'b0;
      else if (fb[1] == 8'h60) m_cat = 8'hFF;
    end else if (cmd >= 8'h40 && cmd <= 8'h44) begin
      if (fb[17] != cmd) err_inc();
      else if (cmd == 8'h42) m_key = body;
      else if (cmd == 8'h43) m_pt = body;
      else if (cmd == 8'h40) begin do_tx = 1'b1; exp_pl = secret_flag; end
      else begin do_tx = 1'b1; exp_pl = {8'h44, aes_out, 8'h44}; end
    end else begin
      err_inc();
    end
  endtask

  task automatic send_frame();
    u_if.frame       = pack_frame();
    u_if.frame_valid = 1'b1;
    step();
    u_if.frame_valid = 1'b0;
    step();
  endtask

  task automatic check_regs(input string tag);
    chk({tag, "_cat"}, W'(cat_status), W'(m_cat));
    chk({tag, "_key"}, W'(aes_key), W'(m_key));
    chk({tag, "_pt"},  W'(aes_in), W'(m_pt));
    chk({tag, "_err"}, W'(err_count), W'(m_err));
  endtask

  task automatic wait_trigger(input int max, output int n);
    n = 0;
    while (!u_if.tx_trigger && n < max) begin
      step();
      n++;
    end
  endtask

  // UART transmitter response: busy one cycle after the trigger, held for 'hold' cycles.
  task automatic tx_ack(input int hold);
    step();
    chk("trig_single", W'(u_if.tx_trigger), W'(0));
    u_if.tx_busy = 1'b1;
    repeat (hold) step();
    chk("busy_during_tx", W'(busy), W'(1));
    u_if.tx_busy = 1'b0;
    step();
    chk("busy_after_tx", W'(busy), W'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, trig_seen;
    bit do_tx, valid;
    logic [W-1:0] exp_pl;
    byte unsigned cmd;
    int sel;

    reset            = 1'b1;
    u_if.frame_valid = 1'b0;
    u_if.frame       = '0;
    u_if.tx_busy     = 1'b0;
    aes_out          = '0;
    for (int k = 0; k < W / 32; k++) secret_flag[32*k +: 32] = $urandom;
    m_cat = 8'hFF; m_err = 8'h00; m_key = '0; m_pt = '0;
    repeat (3) step();
    reset = 1'b0;
    step();

    // reset state
    check_regs("reset");
    chk("reset_payload", u_if.tx_payload, '0);
    chk("reset_trigger", W'(u_if.tx_trigger), W'(0));
    chk("reset_busy", W'(busy), W'(0));

    // cat clear, latency, reset char, out-of-range
    clear_fb(); fb[0] = 8'h41; fb[1] = 8'h43; fb[2] = 8'h41;
    u_if.frame = pack_frame(); u_if.frame_valid = 1'b1;
    step(); u_if.frame_valid = 1'b0;
    chk("cat_latency_n1", W'(cat_status), W'(8'hFF));
    chk("busy_in_decode", W'(busy), W'(1));
    step();
    chk("cat_clear", W'(cat_status), W'(8'hFB));
    m_cat = 8'hFB;
    clear_fb(); fb[0] = 8'h41; fb[1] = 8'h60; fb[2] = 8'h41;
    send_frame();
    chk("cat_reset_char", W'(cat_status), W'(8'hFF));
    m_cat = 8'hFF;
    clear_fb(); fb[0] = 8'h41; fb[1] = 8'h49; fb[2] = 8'h41;
    send_frame();
    check_regs("cat_out_of_range");

    // key load, then same payload with bad end char
    clear_fb(); fb[0] = 8'h42;
    for (int i = 1; i <= 16; i++) fb[i] = 8'(i - 1);
    fb[17] = 8'h42;
    send_frame();
    chk("key_load", W'(aes_key), W'(128'h0F0E0D0C0B0A09080706050403020100));
    m_key = 128'h0F0E0D0C0B0A09080706050403020100;
    fb[17] = 8'h43;
    send_frame();
    chk("key_bad_end_err", W'(err_count), W'(1));
    chk("key_bad_end_keep", W'(aes_key), W'(m_key));
    m_err = 8'd1;

    // encrypt: trigger exactly 5 cycles after frame_valid
    aes_out = {$urandom, $urandom, $urandom, $urandom};
    clear_fb(); fb[0] = 8'h44; fb[17] = 8'h44;
    send_frame();
    chk("enc_busy_wait", W'(busy), W'(1));
    wait_trigger(20, n);
    chk("enc_trigger_seen", W'(u_if.tx_trigger), W'(1));
    chk("enc_trigger_delay", W'(n + 2), W'(5));
    chk("enc_payload", u_if.tx_payload, {8'h44, aes_out, 8'h44});
    tx_ack(3);
    check_regs("enc_done");

    // flag while transmitter busy
    u_if.tx_busy = 1'b1;
    clear_fb(); fb[0] = 8'h40; fb[17] = 8'h40;
    send_frame();
    trig_seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (u_if.tx_trigger) trig_seen++;
      step();
    end
    chk("flag_hold_no_trig", W'(trig_seen), W'(0));
    u_if.tx_busy = 1'b0;
    #1;
    chk("flag_trigger", W'(u_if.tx_trigger), W'(1));
    chk("flag_payload", u_if.tx_payload, secret_flag);
    #1;
    tx_ack(2);

    // frame dropped during AES_WAIT, then acknowledge timeout
    clear_fb(); fb[0] = 8'h44; fb[17] = 8'h44;
    u_if.frame = pack_frame(); u_if.frame_valid = 1'b1;
    step(); u_if.frame_valid = 1'b0;
    step();
    clear_fb(); fb[0] = 8'h41; fb[1] = 8'h41; fb[2] = 8'h41;
    u_if.frame = pack_frame(); u_if.frame_valid = 1'b1;
    step(); u_if.frame_valid = 1'b0;
    err_inc();
    wait_trigger(20, n);
    chk("drop_enc_trigger", W'(u_if.tx_trigger), W'(1));
    chk("drop_enc_delay", W'(n + 3), W'(5));
    chk("drop_err", W'(err_count), W'(m_err));
    chk("drop_cat_untouched", W'(cat_status), W'(m_cat));
    repeat (4) step();
    chk("tmo_busy_before", W'(busy), W'(1));
    chk("tmo_err_before", W'(err_count), W'(m_err));
    step();
    err_inc();
    chk("tmo_err_after", W'(err_count), W'(m_err));
    chk("tmo_idle", W'(busy), W'(0));

    // randomized frames against the model
    for (int it = 0; it < 40; it++) begin
      for (int k = 0; k < 18; k++) fb[k] = 8'($urandom);
      sel   = $urandom_range(0, 5);
      valid = ($urandom_range(0, 3) != 0);
      case (sel)
        0: cmd = 8'h41;
        1: cmd = 8'h42;
        2: cmd = 8'h43;
        3: cmd = 8'h44;
        4: cmd = 8'h40;
        default: begin
          cmd = 8'($urandom);
          while (cmd >= 8'h40 && cmd <= 8'h44) cmd = 8'($urandom);
        end
      endcase
      fb[0] = cmd;
      if (sel == 0) begin
        if ($urandom_range(0, 1) == 1) fb[1] = 8'(8'h41 + $urandom_range(0, 7));
        else if ($urandom_range(0, 3) == 0) fb[1] = 8'h60;
        fb[2] = valid ? cmd : (cmd ^ 8'($urandom_range(1, 255)));
      end else begin
        fb[17] = valid ? cmd : (cmd ^ 8'($urandom_range(1, 255)));
      end
      aes_out = {$urandom, $urandom, $urandom, $urandom};
      apply_model(do_tx, exp_pl);
      send_frame();
      if (do_tx) begin
        wait_trigger(20, n);
        chk("rnd_trigger", W'(u_if.tx_trigger), W'(1));
        chk("rnd_payload", u_if.tx_payload, exp_pl);
        tx_ack($urandom_range(1, 3));
      end
      check_regs("rnd");
    end

    // reset during TX_WAIT
    clear_fb(); fb[0] = 8'h41; fb[1] = 8'h48; fb[2] = 8'h41;
    send_frame();
    clear_fb(); fb[0] = 8'h44; fb[17] = 8'h44;
    send_frame();
    wait_trigger(20, n);
    chk("rst_pre_trigger", W'(u_if.tx_trigger), W'(1));
    step();
    u_if.tx_busy = 1'b1;
    step();
    step();
    #2;
    reset = 1'b1;
    #1;
    chk("rst_async_cat", W'(cat_status), W'(8'hFF));
    chk("rst_async_err", W'(err_count), W'(0));
    chk("rst_async_key", W'(aes_key), W'(0));
    chk("rst_async_pt", W'(aes_in), W'(0));
    chk("rst_async_payload", u_if.tx_payload, '0);
    chk("rst_async_busy", W'(busy), W'(0));
    u_if.tx_busy = 1'b0;
    chk("rst_async_trigger", W'(u_if.tx_trigger), W'(0));
    m_cat = 8'hFF; m_err = 8'h00; m_key = '0; m_pt = '0;
    repeat (2) step();
    reset = 1'b0;
    trig_seen = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (u_if.tx_trigger) trig_seen++;
    end
    chk("rst_no_trigger", W'(trig_seen), W'(0));
    check_regs("rst_after");

    // err_count saturation with 300 bad frames
    clear_fb();
    for (int i = 0; i < 300; i++) begin
      send_frame();
      err_inc();
      if (i == 99) chk("sat_mid", W'(err_count), W'(m_err));
    end
    chk("sat_final", W'(err_count), W'(8'd255));
    chk("sat_model", W'(err_count), W'(m_err));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
